// File: rtl/freq_meter_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } fm_state_t;

  localparam int DEF_GATE_CYCLES = 180;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic Reset,
  input  logic sig,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_prev_reg;
  logic                   edge_reg;

  // Stage 0 captures the raw input; each later stage takes its predecessor.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign sync_next[gi] = sig;
    end else begin : g_rest
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
      edge_reg      <= 1'b0;
    end else begin
      sync_reg      <= sync_next;
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
      edge_reg      <= sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
    end
  end

  assign edge_det = edge_reg;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter for the ring-oscillator output with a Start/Done handshake.
// Define FREQ_METER_SAT_EN to make the counter saturate and report Overflow.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             OscIn,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow
);

  localparam int TMR_W = $clog2(GATE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  fm_state_t        state_reg, state_next;
  logic [TMR_W-1:0] timer_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] count_reg;
  logic             edge_det;
  logic             gate_last;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .Reset    (Reset),
    .sig      (OscIn),
    .edge_det (edge_det)
  );

  assign gate_last = (state_reg == GATE) && (timer_reg == TMR_LAST);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = Start ? ARM : IDLE;
      ARM:     state_next = GATE;
      GATE:    state_next = gate_last ? DONE : GATE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_reg != IDLE);
    Done = (state_reg == DONE);
  end

`ifdef FREQ_METER_SAT_EN
  logic ovf_reg, ovf_next;
  logic overflow_reg;

  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (state_reg == ARM) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (state_reg == GATE && edge_det) begin
      if (cnt_reg == {CNT_W{1'b1}}) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      ovf_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
      if (gate_last) begin
        overflow_reg <= ovf_next;
      end
    end
  end

  assign Overflow = overflow_reg;
`else
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ARM) begin
      cnt_next = '0;
    end else if (state_reg == GATE && edge_det) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign Overflow = 1'b0;
`endif

  // The result is taken from cnt_next so an edge in the last gate cycle counts
  // and Count changes in the same cycle Done is high.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      timer_reg <= '0;
      cnt_reg   <= '0;
      count_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (state_reg == ARM) begin
        timer_reg <= '0;
      end else if (state_reg == GATE) begin
        timer_reg <= timer_reg + 1'b1;
      end
      if (gate_last) begin
        count_reg <= cnt_next;
      end
    end
  end

  assign Count = count_reg;

endmodule
